// File: rtl/img_bram_arb.sv
// Image BRAM port arbiter: reads win combinationally, the AXI-Stream loader fills DEPTH pixels when the port is free.
// Zero-latency address/enable path; tready drops whenever a read or a load restart claims the cycle. Optional IMG_BRAM_ARB_STALL_CNT_EN adds stall_cnt_o.
module img_bram_arb #(
    parameter int DATAW = 24,
    parameter int ADDRW = 17,
    parameter int DEPTH = 111000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en_i,
    input  logic [ADDRW-1:0] rd_addr_i,
    output logic [DATAW-1:0] rd_data_o,
    input  logic             load_start,
    input  logic [DATAW-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tuser,
    output logic             s_axis_tready,
    output logic             load_done,
    output logic             img_valid,
    output logic             bram_en_o,
    output logic             bram_we_o,
    output logic [ADDRW-1:0] bram_addr_o,
    output logic [DATAW-1:0] bram_wdata_o,
    input  logic [DATAW-1:0] bram_rdata_i
`ifdef IMG_BRAM_ARB_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt_o
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);
    localparam logic [ADDRW-1:0] ADDR_ONE  = ADDRW'(1);

    logic [1:0]       state_q, state_d;
    logic [ADDRW-1:0] wr_addr_q, wr_addr_d;
    logic             img_valid_q, img_valid_d;
    logic             load_done_q, load_done_d;

    logic             tready;
    logic             beat_acc;
    logic [ADDRW-1:0] beat_addr;

    always_comb begin
        // rst gates tready so a load in flight cannot write during the reset cycle
        tready    = !rst && (state_q == S_LOAD) && !rd_en_i && !load_start;
        beat_acc  = tready && s_axis_tvalid;
        beat_addr = s_axis_tuser ? '0 : wr_addr_q;

        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        img_valid_d = img_valid_q;
        load_done_d = 1'b0;

        if (load_start) begin
            state_d     = S_LOAD;
            wr_addr_d   = '0;
            img_valid_d = 1'b0;
        end else if (beat_acc) begin
            if (beat_addr == LAST_ADDR) begin
                state_d     = S_DONE;
                wr_addr_d   = '0;
                img_valid_d = 1'b1;
                load_done_d = 1'b1;
            end else begin
                wr_addr_d = beat_addr + ADDR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_addr_q   <= '0;
            img_valid_q <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            img_valid_q <= img_valid_d;
            load_done_q <= load_done_d;
        end
    end

    always_comb begin
        bram_en_o    = rd_en_i || beat_acc;
        bram_we_o    = beat_acc;
        bram_wdata_o = s_axis_tdata;
        if (rd_en_i) begin
            bram_addr_o = rd_addr_i;
        end else if (beat_acc) begin
            bram_addr_o = beat_addr;
        end else begin
            bram_addr_o = '0;
        end
    end

    assign s_axis_tready = tready;
    assign load_done     = load_done_q;
    assign img_valid     = img_valid_q;
    assign rd_data_o     = bram_rdata_i;

`ifdef IMG_BRAM_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (load_start) begin
            stall_cnt_d = '0;
        end else if ((state_q == S_LOAD) && s_axis_tvalid && rd_en_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_img_bram_arb.sv
// Scoreboard bench for img_bram_arb; image depth scaled down so full loads stay short.
module tb_img_bram_arb;

    localparam int DATAW    = 24;
    localparam int ADDRW    = 17;
    localparam int TB_DEPTH = 1200;

    logic             clk;
    logic             rst;
    logic             rd_en_i;
    logic [ADDRW-1:0] rd_addr_i;
    logic [DATAW-1:0] rd_data_o;
    logic             load_start;
    logic [DATAW-1:0] s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tuser;
    logic             s_axis_tready;
    logic             load_done;
    logic             img_valid;
    logic             bram_en_o;
    logic             bram_we_o;
    logic [ADDRW-1:0] bram_addr_o;
    logic [DATAW-1:0] bram_wdata_o;
    logic [DATAW-1:0] bram_rdata_i;
`ifdef IMG_BRAM_ARB_STALL_CNT_EN
    logic [31:0]      stall_cnt_o;
`endif

    img_bram_arb #(.DATAW(DATAW), .ADDRW(ADDRW), .DEPTH(TB_DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_en_i       (rd_en_i),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
        .load_start    (load_start),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .load_done     (load_done),
        .img_valid     (img_valid),
        .bram_en_o     (bram_en_o),
        .bram_we_o     (bram_we_o),
        .bram_addr_o   (bram_addr_o),
        .bram_wdata_o  (bram_wdata_o),
        .bram_rdata_i  (bram_rdata_i)
`ifdef IMG_BRAM_ARB_STALL_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 load, 2 done
    int               m_state = 0;
    logic [ADDRW-1:0] m_wr    = '0;
    logic             m_valid = 1'b0;
    logic             m_done  = 1'b0;

    logic [ADDRW+DATAW-1:0] sb_q[$];
    logic                   written[TB_DEPTH];
    int                     done_cnt;

    task automatic set_in(input logic ls, input logic v, input logic u, input logic re,
                          input logic [ADDRW-1:0] ra);
        load_start    = ls;
        s_axis_tvalid = v;
        s_axis_tuser  = u;
        rd_en_i       = re;
        rd_addr_i     = ra;
        s_axis_tdata  = DATAW'($urandom);
        bram_rdata_i  = DATAW'($urandom);
    endtask

    task automatic step();
        logic                   exp_rdy;
        logic                   acc;
        logic [ADDRW-1:0]       waddr;
        logic [ADDRW+DATAW-1:0] e;
        @(negedge clk);
        exp_rdy = !rst && (m_state == 1) && !rd_en_i && !load_start;
        acc     = exp_rdy && s_axis_tvalid;
        waddr   = s_axis_tuser ? '0 : m_wr;
        chk("tready", 64'(s_axis_tready), 64'(exp_rdy));
        chk("bram_en", 64'(bram_en_o), 64'(rd_en_i | acc));
        chk("bram_we", 64'(bram_we_o), 64'(acc));
        if (rd_en_i) chk("rd_addr", 64'(bram_addr_o), 64'(rd_addr_i));
        chk("rd_data", 64'(rd_data_o), 64'(bram_rdata_i));
        chk("img_valid", 64'(img_valid), 64'(m_valid));
        chk("load_done", 64'(load_done), 64'(m_done));
        if (load_done === 1'b1) done_cnt++;
        if (acc) sb_q.push_back({waddr, s_axis_tdata});
        if (bram_we_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_wr", 64'(1), 64'(0));
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", 64'(bram_addr_o), 64'(e[ADDRW+DATAW-1:DATAW]));
                chk("wr_data", 64'(bram_wdata_o), 64'(e[DATAW-1:0]));
                if (int'(bram_addr_o) < TB_DEPTH) written[int'(bram_addr_o)] = 1'b1;
            end
        end
        @(posedge clk);
        m_done = 1'b0;
        if (rst) begin
            m_state = 0; m_wr = '0; m_valid = 1'b0;
        end else if (load_start) begin
            m_state = 1; m_wr = '0; m_valid = 1'b0;
        end else if (acc) begin
            if (int'(waddr) == TB_DEPTH - 1) begin
                m_state = 2; m_wr = '0; m_valid = 1'b1; m_done = 1'b1;
            end else begin
                m_wr = waddr + ADDRW'(1);
            end
        end
        #1;
    endtask

    task automatic drive(input logic ls, input logic v, input logic u, input logic re,
                         input logic [ADDRW-1:0] ra);
        set_in(ls, v, u, re, ra);
        step();
    endtask

    initial begin
        int nw;
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Reset: stream ignored, reads still pass through
        repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        set_in(1'b0, 1'b1, 1'b0, 1'b1, ADDRW'(77));
        #1;
        chk("rst_read_addr", 64'(bram_addr_o), 64'(77));
        chk("rst_read_en", 64'(bram_en_o), 64'(1));
        step();
        rst = 1'b0;

        // Idle ignores tvalid
        repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, '0);

        // Full back-to-back load
        foreach (written[i]) written[i] = 1'b0;
        done_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < TB_DEPTH; i++) drive(1'b0, 1'b1, (i == 0), 1'b0, '0);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        nw = 0;
        foreach (written[i]) if (written[i]) nw++;
        chk("full_written", 64'(nw), 64'(TB_DEPTH));
        chk("full_done_pulses", 64'(done_cnt), 64'(1));
        chk("full_img_valid", 64'(img_valid), 64'(1));

        // Restart, then read preemption at wr_addr 40
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("restart_clears_valid", 64'(img_valid), 64'(0));
        repeat (40) drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        set_in(1'b0, 1'b1, 1'b0, 1'b1, ADDRW'(500));
        #1;
        chk("preempt_tready", 64'(s_axis_tready), 64'(0));
        chk("preempt_we", 64'(bram_we_o), 64'(0));
        chk("preempt_addr", 64'(bram_addr_o), 64'(500));
        step();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, '0);
        #1;
        chk("after_preempt_addr", 64'(bram_addr_o), 64'(40));
        step();

        // tuser beat at wr_addr 41 restarts the frame at 0
        set_in(1'b0, 1'b1, 1'b1, 1'b0, '0);
        #1;
        chk("tuser_addr", 64'(bram_addr_o), 64'(0));
        chk("tuser_we", 64'(bram_we_o), 64'(1));
        step();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, '0);
        #1;
        chk("after_tuser_addr", 64'(bram_addr_o), 64'(1));
        step();

        // load_start at wr_addr 700
        for (int i = 2; i < 700; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, '0);
        #1;
        chk("ls_tready", 64'(s_axis_tready), 64'(0));
        chk("ls_we", 64'(bram_we_o), 64'(0));
        step();
        chk("ls_img_valid", 64'(img_valid), 64'(0));
        set_in(1'b0, 1'b1, 1'b0, 1'b0, '0);
        #1;
        chk("ls_next_addr", 64'(bram_addr_o), 64'(0));
        step();

        // rst at wr_addr 1000 abandons the load
        for (int i = 1; i < 1000; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        rst = 1'b1;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, '0);
        #1;
        chk("midrst_tready", 64'(s_axis_tready), 64'(0));
        chk("midrst_we", 64'(bram_we_o), 64'(0));
        step();
        rst = 1'b0;
        repeat (5) drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("midrst_img_valid", 64'(img_valid), 64'(0));

        // Load with random read interference and gaps
        done_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int c = 0; c < 6 * TB_DEPTH && m_state != 2; c++)
            drive(1'b0, ($urandom_range(3) != 0), 1'b0, ($urandom_range(2) == 0),
                  ADDRW'($urandom_range(TB_DEPTH - 1)));
        repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("rand_img_valid", 64'(img_valid), 64'(1));
        chk("rand_done_pulses", 64'(done_cnt), 64'(1));
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("done_restart_valid", 64'(img_valid), 64'(0));

`ifdef IMG_BRAM_ARB_STALL_CNT_EN
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        repeat (25) drive(1'b0, 1'b1, 1'b0, 1'b1, ADDRW'(3));
        chk("stall_25", 64'(stall_cnt_o), 64'(25));
        drive(1'b1, 1'b1, 1'b0, 1'b1, ADDRW'(3));
        chk("stall_clear", 64'(stall_cnt_o), 64'(0));
`endif

        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
